// File: rtl/xy_symbol_tx.sv
// rtl/xy_symbol_tx.sv - count-command transmitter for the two-wire (x,y) increment protocol
// Emits the shortest 11/single symbol sequence for each command and shadows the receiver state.
module xy_symbol_tx #(
  parameter int CNT_W       = 8,
  parameter int GAP         = 0,
  parameter int ONE_SYM_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             x,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase,
  output logic             z_pred
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [3:0]       gcnt, gcnt_nxt;
  logic             pick;
  logic             fin;
  logic [CNT_W-1:0] src;
  logic             two;
  logic [CNT_W-1:0] dec;
  logic             x_nxt, y_nxt;

  // The symbol is chosen from the command itself on the accept edge, otherwise from rem.
  assign src = (state == S_IDLE) ? cmd_cnt : rem;
  assign two = (src >= CNT_W'(2));
  assign dec = two ? CNT_W'(2) : CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rem   <= '0;
      gcnt  <= '0;
      x     <= 1'b0;
      y     <= 1'b0;
      done  <= 1'b0;
      phase <= 2'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      gcnt  <= gcnt_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      done  <= fin;
      // Receiver samples the registered symbol on this same edge.
      phase <= phase + {x & y, x ^ y};
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    gcnt_nxt  = gcnt;
    pick      = 1'b0;
    fin       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_cnt == '0) fin = 1'b1;
          else               pick = 1'b1;
        end
      end
      S_SEND: begin
        if (rem == '0) begin
          state_nxt = S_IDLE;
          fin       = 1'b1;
        end else if (GAP > 0) begin
          state_nxt = S_GAP;
          gcnt_nxt  = GAP_LAST;
        end else begin
          pick = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt == 4'd0) pick = 1'b1;
        else              gcnt_nxt = gcnt - 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (pick) begin
      state_nxt = S_SEND;
      rem_nxt   = src - dec;
    end
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    x_nxt     = pick & (two | (ONE_SYM_SEL == 0));
    y_nxt     = pick & (two | (ONE_SYM_SEL != 0));
    z_pred    = (phase == 2'd0);
  end

endmodule

// File: tb/tb_xy_symbol_tx.sv
// tb/tb_xy_symbol_tx.sv - directed bench for xy_symbol_tx
// Two instances: GAP=0/10-symbol and GAP=2/01-symbol, each followed by a receiver model.
module tb_xy_symbol_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] c0 = '0, c1 = '0;
  logic       r0, x0, y0, b0, d0, z0;
  logic       r1, x1, y1, b1, d1, z1;
  logic [1:0] p0, p1;
  logic [1:0] rx0, rx1;
  int         errors = 0;
  int         checks = 0;
  int         n;

  always #5 clk = ~clk;

  xy_symbol_tx #(.CNT_W(8), .GAP(0), .ONE_SYM_SEL(0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(r0), .cmd_cnt(c0),
    .x(x0), .y(y0), .busy(b0), .done(d0), .phase(p0), .z_pred(z0));

  xy_symbol_tx #(.CNT_W(8), .GAP(2), .ONE_SYM_SEL(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(r1), .cmd_cnt(c1),
    .x(x1), .y(y1), .busy(b1), .done(d1), .phase(p1), .z_pred(z1));

  // Mod-4 ones-counting receiver: 00 +0, 10/01 +1, 11 +2.
  always @(posedge clk) begin
    if (rst) begin
      rx0 <= 2'd0;
      rx1 <= 2'd0;
    end else begin
      rx0 <= rx0 + ((x0 && y0) ? 2'd2 : ((x0 || y0) ? 2'd1 : 2'd0));
      rx1 <= rx1 + ((x1 && y1) ? 2'd2 : ((x1 || y1) ? 2'd1 : 2'd0));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then cross-check both shadows against the receiver models.
  task automatic cyc();
    @(posedge clk);
    #1;
    chk("phase0_vs_rx", {30'd0, p0}, {30'd0, rx0});
    chk("z0_vs_rx", {31'd0, z0}, {31'd0, rx0 == 2'd0});
    chk("phase1_vs_rx", {30'd0, p1}, {30'd0, rx1});
    chk("z1_vs_rx", {31'd0, z1}, {31'd0, rx1 == 2'd0});
  endtask

  // {x,y,busy,ready,done}
  task automatic st0(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, x0, y0, b0, r0, d0}, {27'd0, exp});
  endtask

  task automatic st1(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, x1, y1, b1, r1, d1}, {27'd0, exp});
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    st0("rst_state0", 5'b00010);
    chk("rst_phase0", {30'd0, p0}, 32'd0);
    chk("rst_z0", {31'd0, z0}, 32'd1);
    st1("rst_state1", 5'b00010);
    rst = 1'b0;
    cyc();
    st0("idle0", 5'b00010);

    // 2: GAP=0, cnt=5 -> 11,11,10
    v0 = 1'b1; c0 = 8'd5;
    cyc(); st0("c5_sym1", 5'b11100); chk("c5_ph1", {30'd0, p0}, 32'd0);
    v0 = 1'b0;
    cyc(); st0("c5_sym2", 5'b11100); chk("c5_ph2", {30'd0, p0}, 32'd2);
    cyc(); st0("c5_sym3", 5'b10100); chk("c5_ph3", {30'd0, p0}, 32'd0);
    cyc(); st0("c5_done", 5'b00011); chk("c5_ph4", {30'd0, p0}, 32'd1);
    chk("c5_z", {31'd0, z0}, 32'd0);
    cyc(); st0("c5_after", 5'b00010);

    // 3: cnt=0 -> immediate done, no symbols
    v0 = 1'b1; c0 = 8'd0;
    cyc(); st0("c0_done", 5'b00011);
    v0 = 1'b0;
    cyc(); st0("c0_after", 5'b00010); chk("c0_ph", {30'd0, p0}, 32'd1);

    // 4: back-to-back 4 then 3 with valid held, from a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_ph", {30'd0, p0}, 32'd0);
    v0 = 1'b1; c0 = 8'd4;
    cyc(); st0("bb_s1", 5'b11100);
    c0 = 8'd3;
    cyc(); st0("bb_s2", 5'b11100);
    cyc(); st0("bb_done1", 5'b00011);
    cyc(); st0("bb_s3", 5'b11100);
    v0 = 1'b0;
    cyc(); st0("bb_s4", 5'b10100);
    cyc(); st0("bb_done2", 5'b00011); chk("bb_ph", {30'd0, p0}, 32'd3);

    // 5: GAP=2, 01 single symbol, cnt=3 -> 11,00,00,01
    v1 = 1'b1; c1 = 8'd3;
    cyc(); st1("g_s1", 5'b11100);
    v1 = 1'b0;
    cyc(); st1("g_gap1", 5'b00100);
    cyc(); st1("g_gap2", 5'b00100);
    cyc(); st1("g_s2", 5'b01100);
    cyc(); st1("g_done", 5'b00011); chk("g_ph", {30'd0, p1}, 32'd3);
    cyc(); st1("g_after", 5'b00010);

    // 6: cnt=255, aborted by reset after 10 symbol cycles
    v0 = 1'b1; c0 = 8'd255;
    cyc();
    v0 = 1'b0;
    for (int i = 1; i < 10; i++) cyc();
    st0("max_sym10", 5'b11100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    st0("abort_state", 5'b00010);
    chk("abort_ph", {30'd0, p0}, 32'd0);
    cyc();
    st0("abort_nodone", 5'b00010);

    // full-length 255 run: 128 symbol cycles, final phase 3
    v0 = 1'b1; c0 = 8'd255;
    cyc();
    v0 = 1'b0;
    n = 0;
    while (b0 && n < 300) begin
      n++;
      cyc();
    end
    chk("max_sym_cycles", n, 32'd128);
    st0("max_done", 5'b00011);
    chk("max_ph", {30'd0, p0}, 32'd3);
    chk("max_z", {31'd0, z0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
